neuron_accum: RTL and testbench
===============================

Name: neuron_accum

Overview:
Downstream stage of the TCAM synapse memory. It consumes the per-hit destination neuron ID and synaptic weight produced in fire mode, and integrates them into per-neuron membrane potentials. On each timestep tick it sweeps all neurons, applies leak, and emits spike IDs for neurons at or above threshold through a valid/ready FIFO. That FIFO feeds the packet-injection path back into PacketID_In.

Parameters:
ID_Width, 4, neuron ID width; neuron count N = 2^ID_Width
Weight_Width, 4, signed two's-complement weight width
Pot_Width, 8, signed membrane potential width
Threshold, 64, fire threshold (signed, Pot_Width bits)
Leak, 1, per-tick magnitude decay toward zero (unsigned, Pot_Width-1 bits)
FIFO_Depth, 4, spike output FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
Hit_In  input  1  valid strobe for one synaptic event
DstID_In  input  ID_Width  destination neuron of the event
Weight_In  input  Weight_Width  signed weight of the event
Tick_In  input  1  end-of-timestep pulse; starts the leak/fire sweep
Busy_Out  output  1  sweep in progress; upstream must hold Hit_In/Tick_In low
Spike_Valid_Out  output  1  spike FIFO non-empty
Spike_ID_Out  output  ID_Width  neuron ID at the FIFO head
Spike_Ready_In  input  1  consumer accepts the head when high with valid
Err_Out  output  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=1 at an edge):
  - all N potentials <= 0; FIFO emptied; state <= IDLE; sweep index <= 0.
  - Busy_Out=0, Spike_Valid_Out=0, Spike_ID_Out=0, Err_Out=0.
  - Reset mid-sweep aborts the sweep. Queued spikes are discarded.
- States: IDLE and SWEEP.
- IDLE, Hit_In=1:
  - pot[DstID_In] <= sat(pot + sign-extended Weight_In), visible at the next edge.
  - Saturation clamps to [-2^(Pot_Width-1), 2^(Pot_Width-1)-1]; the value never wraps.
  - One hit per cycle. Back-to-back hits to the same ID accumulate with no lost updates (read-modify-write forwarding is required).
- IDLE, Tick_In=1: next state SWEEP, index=0, Busy_Out=1 from the next cycle.
- IDLE, Hit_In and Tick_In in the same cycle: the hit is applied in that cycle. The sweep then sees the updated potential.
- SWEEP, one neuron per cycle at index i:
  - if pot[i] >= Threshold (signed compare): push i into the FIFO and set pot[i] <= 0.
  - else if pot[i] > 0: pot[i] <= pot[i] - min(Leak, pot[i]).
  - else if pot[i] < 0: pot[i] <= pot[i] + min(Leak, -pot[i]).
  - else pot[i] is unchanged.
- Sweep stall: if pot[i] >= Threshold and the FIFO is full (with no pop this cycle), index i is held and pot[i] is unchanged. Retry happens every cycle; Busy_Out stays 1.
- Sweep end: after index N-1 is processed, next state is IDLE and Busy_Out=0. The unstalled sweep length is exactly N cycles of Busy_Out=1.
- Protocol errors during SWEEP:
  - Hit_In=1: the event is dropped and Err_Out <= 1.
  - Tick_In=1: ignored and Err_Out <= 1.
  - Err_Out clears only on rst.
- FIFO:
  - Spike_ID_Out is the head entry; Spike_Valid_Out = !empty.
  - A pop occurs on valid && ready.
  - Spike_ID_Out holds stable while valid && !ready.
  - Push and pop in the same cycle are allowed when full: the pop frees a slot, so the push succeeds and the sweep does not stall.
  - A pushed spike becomes visible at the output the cycle after the push.
  - Output order is ascending neuron ID within a tick.

Test Plan:
- Basic fire:
  - Stimulus: after rst, 10 hits ID=3 weight=7 (pot 70), then Tick, ready=1.
  - Response: Busy_Out high for exactly 16 cycles; exactly one spike with ID 3; pot[3]=0 afterwards; a second Tick produces no spike.
- Saturation:
  - Stimulus: 20 hits ID=5 weight=+7; 20 hits ID=6 weight=-8; then Tick.
  - Response: pot[5]=127 fires (ID 5), then pot[5]=0; pot[6] goes -128 to -127 after leak, with no spike.
- Leak:
  - Stimulus: ID=2 weight=+5 and ID=9 weight=-3, then 6 Ticks.
  - Response: pot[2] goes 4,3,2,1,0,0; pot[9] goes -2,-1,0,0,0,0; no spikes.
- Backpressure:
  - Stimulus: IDs 0..5 each 10 hits weight=7; ready=0; Tick.
  - Response: FIFO fills with 0,1,2,3; sweep stalls at index 4 with Busy_Out=1.
  - Stimulus: ready=1.
  - Response: spikes 0,1,2,3,4,5 in order; sweep completes and Busy_Out falls.
- Protocol error and reset:
  - Stimulus: Hit ID=1 weight=7 during Busy_Out.
  - Response: dropped (pot[1] unchanged); Err_Out=1 and stays 1; extra Tick during the sweep is ignored.
  - Stimulus: rst mid-sweep.
  - Response: Busy_Out=0, Spike_Valid_Out=0, Err_Out=0 the next cycle.
- Simultaneous events:
  - Stimulus: pot[7]=63, then Hit ID=7 weight=1 together with Tick; plus back-to-back hits ID=4 weight=7 ×3 (cycles n..n+2).
  - Response: spike ID 7 in that sweep; pot[4]=21 before leak.

Source files
------------

// File: rtl/neuron_accum.sv
//============================================================================
// Module   : neuron_accum
// Purpose  : Integrates synaptic hits into per-neuron membrane potentials and,
//            on each tick, sweeps all neurons to apply leak and queue spikes.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module neuron_accum #(
  parameter int ID_Width     = 4,
  parameter int Weight_Width = 4,
  parameter int Pot_Width    = 8,
  parameter int Threshold    = 64,
  parameter int Leak         = 1,
  parameter int FIFO_Depth   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Hit_In,
  input  logic [ID_Width-1:0]     DstID_In,
  input  logic [Weight_Width-1:0] Weight_In,
  input  logic                    Tick_In,
  output logic                    Busy_Out,
  output logic                    Spike_Valid_Out,
  output logic [ID_Width-1:0]     Spike_ID_Out,
  input  logic                    Spike_Ready_In,
  output logic                    Err_Out
);

  localparam int c_N  = 1 << ID_Width;
  localparam int c_AW = $clog2(FIFO_Depth);
  localparam logic signed [Pot_Width-1:0] c_THR   = Pot_Width'(Threshold);
  localparam logic signed [Pot_Width-1:0] c_LEAK  = Pot_Width'(Leak);
  localparam logic signed [Pot_Width-1:0] c_NLEAK = -c_LEAK;
  localparam logic signed [Pot_Width-1:0] c_PMAX  = {1'b0, {(Pot_Width-1){1'b1}}};
  localparam logic signed [Pot_Width-1:0] c_PMIN  = {1'b1, {(Pot_Width-1){1'b0}}};
  localparam logic [ID_Width-1:0]         c_LAST  = ID_Width'(c_N - 1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_SWEEP = 1'b1} state_t;

  state_t                      r_state;
  logic signed [Pot_Width-1:0] r_pot [c_N];
  logic [ID_Width-1:0]         r_idx;
  logic                        r_err;
  logic [ID_Width-1:0]         r_fifo [FIFO_Depth];
  logic [c_AW:0]               r_wptr;
  logic [c_AW:0]               r_rptr;

  logic                        w_empty;
  logic                        w_full;
  logic                        w_pop;
  logic                        w_fire;
  logic                        w_push;
  logic                        w_stall;
  logic signed [Pot_Width-1:0] w_cur;
  logic signed [Pot_Width-1:0] w_next;
  logic signed [Pot_Width-1:0] w_hit_pot;
  logic [Pot_Width:0]          w_sum;
  logic signed [Pot_Width-1:0] w_sat;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign w_pop   = !w_empty && Spike_Ready_In;

  // A same-cycle pop frees the slot, so a full FIFO only stalls without one.
  assign w_cur   = r_pot[r_idx];
  assign w_fire  = (r_state == S_SWEEP) && (w_cur >= c_THR);
  assign w_push  = w_fire && (!w_full || w_pop);
  assign w_stall = w_fire && !w_push;

  always_comb begin
    w_next = w_cur;
    if (w_fire) begin
      w_next = '0;
    end else if (!w_cur[Pot_Width-1] && (w_cur != '0)) begin
      w_next = (w_cur > c_LEAK) ? (w_cur - c_LEAK) : '0;
    end else if (w_cur[Pot_Width-1]) begin
      w_next = (w_cur < c_NLEAK) ? (w_cur + c_LEAK) : '0;
    end
  end

  // One extra bit of headroom exposes overflow in the top two sum bits.
  assign w_hit_pot = r_pot[DstID_In];
  assign w_sum = {w_hit_pot[Pot_Width-1], w_hit_pot} +
                 {{(Pot_Width+1-Weight_Width){Weight_In[Weight_Width-1]}}, Weight_In};

  always_comb begin
    w_sat = w_sum[Pot_Width-1:0];
    if (w_sum[Pot_Width] != w_sum[Pot_Width-1]) begin
      w_sat = w_sum[Pot_Width] ? c_PMIN : c_PMAX;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_err   <= 1'b0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      for (int k = 0; k < c_N; k++) begin
        r_pot[k] <= '0;
      end
    end else begin
      if (w_pop) begin
        r_rptr <= r_rptr + (c_AW+1)'(1);
      end
      if (w_push) begin
        r_fifo[r_wptr[c_AW-1:0]] <= r_idx;
        r_wptr <= r_wptr + (c_AW+1)'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (Hit_In) begin
            r_pot[DstID_In] <= w_sat;
          end
          if (Tick_In) begin
            r_state <= S_SWEEP;
            r_idx   <= '0;
          end
        end
        S_SWEEP: begin
          if (Hit_In || Tick_In) begin
            r_err <= 1'b1;
          end
          if (!w_stall) begin
            r_pot[r_idx] <= w_next;
            r_idx        <= r_idx + ID_Width'(1);
            if (r_idx == c_LAST) begin
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy_Out        = (r_state == S_SWEEP);
  assign Spike_Valid_Out = !w_empty;
  assign Spike_ID_Out    = w_empty ? '0 : r_fifo[r_rptr[c_AW-1:0]];
  assign Err_Out         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_neuron_accum.sv
//============================================================================
// Module   : tb_neuron_accum
// Purpose  : Self-checking bench for neuron_accum with a spike scoreboard.
// Revision : 1.0  initial release
//============================================================================
`default_nettype none

module tb_neuron_accum;

  logic       clk;
  logic       rst;
  logic       Hit_In;
  logic [3:0] DstID_In;
  logic [3:0] Weight_In;
  logic       Tick_In;
  logic       Busy_Out;
  logic       Spike_Valid_Out;
  logic [3:0] Spike_ID_Out;
  logic       Spike_Ready_In;
  logic       Err_Out;

  int n_chk;
  int n_err;
  int n_spk;
  int m_pot [16];
  int exp_q [$];

  neuron_accum dut (
    .clk             (clk),
    .rst             (rst),
    .Hit_In          (Hit_In),
    .DstID_In        (DstID_In),
    .Weight_In       (Weight_In),
    .Tick_In         (Tick_In),
    .Busy_Out        (Busy_Out),
    .Spike_Valid_Out (Spike_Valid_Out),
    .Spike_ID_Out    (Spike_ID_Out),
    .Spike_Ready_In  (Spike_Ready_In),
    .Err_Out         (Err_Out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every accepted spike is matched against the reference order.
  always @(negedge clk) begin
    if (!rst && Spike_Valid_Out && Spike_Ready_In) begin
      n_spk++;
      if (exp_q.size() == 0) chk("spike_extra", int'(Spike_ID_Out), -1);
      else chk("spike_id", int'(Spike_ID_Out), exp_q.pop_front());
    end
  end

  function automatic int sat(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic m_sweep();
    for (int i = 0; i < 16; i++) begin
      if (m_pot[i] >= 64) begin
        exp_q.push_back(i);
        m_pot[i] = 0;
      end else if (m_pot[i] > 0) m_pot[i] = m_pot[i] - 1;
      else if (m_pot[i] < 0) m_pot[i] = m_pot[i] + 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_pot[i] = 0;
    exp_q.delete();
  endtask

  task automatic hit(input int id, input int w);
    Hit_In = 1'b1; DstID_In = 4'(id); Weight_In = 4'(w);
    m_pot[id] = sat(m_pot[id] + w);
    @(posedge clk); #1;
    Hit_In = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (Busy_Out && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic tick(output int cyc);
    Tick_In = 1'b1;
    m_sweep();
    @(posedge clk); #1;
    Tick_In = 1'b0;
    wait_idle(cyc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (Spike_Valid_Out && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_q", exp_q.size(), 0);
  endtask

  initial begin
    int cyc;
    int s0;
    int e2 [6];
    int e9 [6];
    e2 = '{4, 3, 2, 1, 0, 0};
    e9 = '{-2, -1, 0, 0, 0, 0};
    n_chk = 0; n_err = 0; n_spk = 0;
    Hit_In = 0; DstID_In = 0; Weight_In = 0; Tick_In = 0; Spike_Ready_In = 1;

    do_reset();
    chk("rst_busy", int'(Busy_Out), 0);
    chk("rst_valid", int'(Spike_Valid_Out), 0);
    chk("rst_id", int'(Spike_ID_Out), 0);
    chk("rst_err", int'(Err_Out), 0);

    // Basic fire
    for (int k = 0; k < 10; k++) hit(3, 7);
    chk("pot3_pre", int'(dut.r_pot[3]), 70);
    s0 = n_spk;
    tick(cyc);
    chk("busy_len", cyc, 16);
    drain();
    chk("basic_spikes", n_spk - s0, 1);
    chk("pot3_post", int'(dut.r_pot[3]), 0);
    tick(cyc);
    drain();
    chk("basic_second", n_spk - s0, 1);

    // Saturation
    for (int k = 0; k < 20; k++) hit(5, 7);
    for (int k = 0; k < 20; k++) hit(6, -8);
    chk("pot5_sat", int'(dut.r_pot[5]), 127);
    chk("pot6_sat", int'(dut.r_pot[6]), -128);
    s0 = n_spk;
    tick(cyc);
    drain();
    chk("sat_spikes", n_spk - s0, 1);
    chk("pot5_post", int'(dut.r_pot[5]), 0);
    chk("pot6_post", int'(dut.r_pot[6]), -127);

    // Leak
    do_reset();
    hit(2, 5);
    hit(9, -3);
    s0 = n_spk;
    for (int t = 0; t < 6; t++) begin
      tick(cyc);
      chk("leak_pot2", int'(dut.r_pot[2]), e2[t]);
      chk("leak_pot9", int'(dut.r_pot[9]), e9[t]);
    end
    chk("leak_spikes", n_spk - s0, 0);

    // Backpressure
    do_reset();
    Spike_Ready_In = 1'b0;
    for (int id = 0; id < 6; id++)
      for (int k = 0; k < 10; k++) hit(id, 7);
    s0 = n_spk;
    Tick_In = 1'b1;
    m_sweep();
    @(posedge clk); #1;
    Tick_In = 1'b0;
    repeat (30) begin @(posedge clk); #1; end
    chk("bp_busy", int'(Busy_Out), 1);
    chk("bp_valid", int'(Spike_Valid_Out), 1);
    chk("bp_head", int'(Spike_ID_Out), 0);
    chk("bp_idx", int'(dut.r_idx), 4);
    chk("bp_pot4", int'(dut.r_pot[4]), 70);
    Spike_Ready_In = 1'b1;
    wait_idle(cyc);
    chk("bp_done", int'(Busy_Out), 0);
    drain();
    chk("bp_spikes", n_spk - s0, 6);

    // Protocol error
    do_reset();
    hit(1, 7);
    Tick_In = 1'b1;
    m_sweep();
    @(posedge clk); #1;
    Tick_In = 1'b0;
    Hit_In = 1'b1; DstID_In = 4'd1; Weight_In = 4'd7;
    @(posedge clk); #1;
    Hit_In = 1'b0;
    chk("err_set", int'(Err_Out), 1);
    Tick_In = 1'b1;
    @(posedge clk); #1;
    Tick_In = 1'b0;
    wait_idle(cyc);
    chk("err_busy_len", cyc + 2, 16);
    chk("err_pot1", int'(dut.r_pot[1]), 6);
    chk("err_sticky", int'(Err_Out), 1);

    // Reset mid-sweep with a queued spike
    Spike_Ready_In = 1'b0;
    for (int k = 0; k < 10; k++) hit(0, 7);
    Tick_In = 1'b1;
    m_sweep();
    @(posedge clk); #1;
    Tick_In = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_valid_pre", int'(Spike_Valid_Out), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_busy", int'(Busy_Out), 0);
    chk("mid_valid", int'(Spike_Valid_Out), 0);
    chk("mid_err", int'(Err_Out), 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_pot[i] = 0;
    exp_q.delete();
    Spike_Ready_In = 1'b1;

    // Simultaneous hit and tick, back-to-back hits
    do_reset();
    for (int k = 0; k < 9; k++) hit(7, 7);
    hit(4, 7); hit(4, 7); hit(4, 7);
    chk("b2b_pot4", int'(dut.r_pot[4]), 21);
    s0 = n_spk;
    Hit_In = 1'b1; DstID_In = 4'd7; Weight_In = 4'd1; Tick_In = 1'b1;
    m_pot[7] = sat(m_pot[7] + 1);
    m_sweep();
    @(posedge clk); #1;
    Hit_In = 1'b0; Tick_In = 1'b0;
    wait_idle(cyc);
    chk("sim_busy_len", cyc, 16);
    drain();
    chk("sim_spikes", n_spk - s0, 1);
    chk("sim_pot4", int'(dut.r_pot[4]), 20);
    chk("sim_err", int'(Err_Out), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
